// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the byte-RAM arbiter.
//   - MEM request codes (none / load byte / store byte)
//   - owner codes reported on if_or_mem
//   - controller state codes
package mem_ctrl_pkg;

    localparam logic [1:0] MemReqNone  = 2'b00;
    localparam logic [1:0] MemReqLoad  = 2'b01;
    localparam logic [1:0] MemReqStore = 2'b10;

    localparam logic [1:0] OwnerIdle = 2'b00;
    localparam logic [1:0] OwnerIf   = 2'b01;
    localparam logic [1:0] OwnerMem  = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IF0  = 3'd1,
        IF1  = 3'd2,
        IF2  = 3'd3,
        IF3  = 3'd4,
        IF4  = 3'd5,
        MEM  = 3'd6
    } state_t;

    // 2'b11 is treated as no request.
    function automatic logic mem_req_valid(input logic [1:0] req);
        return (req == MemReqLoad) || (req == MemReqStore);
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port byte-RAM arbiter between instruction fetch (IF)
// and the MEM stage.
//   clk, rst        clock, synchronous active-low reset
//   if_request/addr IF word fetch request and word address
//   if_inst_o       assembled little-endian word, valid while if_done=1
//   if_done         one-cycle completion pulse
//   mem_request     00 none, 01 load byte, 10 store byte (11 = none)
//   mem_addr        byte address for MEM
//   mem_data_i/o    store byte in, registered load byte out
//   if_or_mem       current owner: 00 idle, 01 IF, 10 MEM
//   ram_*           RAM port; ram_din valid one edge after ram_a
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_request,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst_o,
    output logic        if_done,
    input  logic [1:0]  mem_request,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_data_i,
    output logic [7:0]  mem_data_o,
    output logic [1:0]  if_or_mem,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);

    state_t      state;
    logic [31:0] base;
    logic [23:0] byte_buf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            base       <= '0;
            byte_buf   <= '0;
            if_inst_o  <= '0;
            if_done    <= 1'b0;
            mem_data_o <= '0;
        end else begin
            if_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req_valid(mem_request)) begin
                        state <= MEM;
                    end else if (if_request) begin
                        state <= IF0;
                        base  <= if_addr;
                    end
                end
                IF0: state <= IF1;
                // Byte k arrives one state after its address was presented.
                IF1: begin
                    byte_buf[7:0] <= ram_din;
                    state         <= IF2;
                end
                IF2: begin
                    byte_buf[15:8] <= ram_din;
                    state          <= IF3;
                end
                IF3: begin
                    byte_buf[23:16] <= ram_din;
                    state           <= IF4;
                end
                // Last byte is merged straight from the RAM bus.
                IF4: begin
                    if_inst_o <= {ram_din, byte_buf};
                    if_done   <= 1'b1;
                    state     <= mem_req_valid(mem_request) ? MEM : IDLE;
                end
                MEM: begin
                    mem_data_o <= ram_din;
                    if (!mem_req_valid(mem_request)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // MEM drives the RAM combinationally so each MEM address costs one cycle.
    always_comb begin
        ram_a     = '0;
        ram_wr    = 1'b0;
        ram_dout  = '0;
        if_or_mem = OwnerIdle;
        case (state)
            IF0: begin
                ram_a     = base;
                if_or_mem = OwnerIf;
            end
            IF1: begin
                ram_a     = base + 32'd1;
                if_or_mem = OwnerIf;
            end
            IF2: begin
                ram_a     = base + 32'd2;
                if_or_mem = OwnerIf;
            end
            IF3: begin
                ram_a     = base + 32'd3;
                if_or_mem = OwnerIf;
            end
            IF4: begin
                if_or_mem = OwnerIf;
            end
            MEM: begin
                ram_a     = mem_addr;
                ram_wr    = (mem_request == MemReqStore);
                ram_dout  = mem_data_i;
                if_or_mem = OwnerMem;
            end
            default: begin
                ram_a     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a cycle-level reference
// model (owner + burst counter + model RAM) and a per-cycle compare process.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_request;
    logic [31:0] if_addr;
    logic [31:0] if_inst_o;
    logic        if_done;
    logic [1:0]  mem_request;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_i;
    logic [7:0]  mem_data_o;
    logic [1:0]  if_or_mem;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    int tests = 0;
    int fails = 0;

    mem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .if_request  (if_request),
        .if_addr     (if_addr),
        .if_inst_o   (if_inst_o),
        .if_done     (if_done),
        .mem_request (mem_request),
        .mem_addr    (mem_addr),
        .mem_data_i  (mem_data_i),
        .mem_data_o  (mem_data_o),
        .if_or_mem   (if_or_mem),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .ram_a       (ram_a),
        .ram_wr      (ram_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Physical RAM driven by the DUT, and an independent model RAM.
    logic [7:0] ram  [logic [31:0]];
    logic [7:0] mram [logic [31:0]];

    function automatic logic [7:0] prd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] mrd(input logic [31:0] a);
        return mram.exists(a) ? mram[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        logic [7:0] t;
        t = prd(ram_a);
        if (ram_wr === 1'b1) ram[ram_a] = ram_dout;
        ram_din <= t;
    end

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram[a]  = d;
        mram[a] = d;
    endtask

    // Reference model: owner 0 idle, 1 IF (step 0..4), 2 MEM.
    int          m_owner = 0;
    int          m_step  = 0;
    logic [31:0] m_base  = '0;
    logic        m_done  = 1'b0;
    logic [31:0] m_inst  = '0;
    logic [7:0]  m_mdo   = '0;
    bit          m_mdo_known = 1'b0;
    logic [7:0]  m_rd    = '0;
    bit          m_rd_known = 1'b0;
    bit          m_live  = 1'b0;

    function automatic bit req_ok(input logic [1:0] r);
        return r == 2'b01 || r == 2'b10;
    endfunction

    function automatic bit addr_known();
        return !(m_owner == 1 && m_step == 4);
    endfunction

    function automatic logic [31:0] exp_addr();
        if (m_owner == 1) return m_base + 32'(m_step);
        if (m_owner == 2) return mem_addr;
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        logic [7:0]  rd_old;
        bit          rd_old_known;
        logic [31:0] ea;
        rd_old       = m_rd;
        rd_old_known = m_rd_known;
        ea           = exp_addr();
        m_rd         = mrd(ea);
        m_rd_known   = addr_known();
        if (m_owner == 2 && mem_request == 2'b10) mram[ea] = mem_data_i;
        m_done = 1'b0;
        if (!rst) begin
            m_owner     = 0;
            m_step      = 0;
            m_inst      = '0;
            m_mdo       = '0;
            m_mdo_known = 1'b1;
            m_live      = 1'b1;
        end else if (m_owner == 0) begin
            if (req_ok(mem_request)) begin
                m_owner = 2;
            end else if (if_request) begin
                m_owner = 1;
                m_step  = 0;
                m_base  = if_addr;
            end
        end else if (m_owner == 1) begin
            if (m_step == 4) begin
                m_inst  = {mrd(m_base + 32'd3), mrd(m_base + 32'd2),
                           mrd(m_base + 32'd1), mrd(m_base)};
                m_done  = 1'b1;
                m_owner = req_ok(mem_request) ? 2 : 0;
            end else begin
                m_step++;
            end
        end else begin
            m_mdo       = rd_old;
            m_mdo_known = rd_old_known;
            if (!req_ok(mem_request)) m_owner = 0;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("owner", 32'(if_or_mem), 32'(m_owner));
            chk("ram_wr", 32'(ram_wr), 32'(m_owner == 2 && mem_request == 2'b10));
            if (addr_known()) chk("ram_a", ram_a, exp_addr());
            if (m_owner != 1) chk("ram_dout", 32'(ram_dout), (m_owner == 2) ? 32'(mem_data_i) : 32'h0);
            chk("if_done", 32'(if_done), 32'(m_done));
            chk("if_inst_o", if_inst_o, m_inst);
            if (m_mdo_known) chk("mem_data_o", 32'(mem_data_o), 32'(m_mdo));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issues a fetch; optionally raises a MEM load when lat reaches mem_at.
    task automatic do_fetch(input logic [31:0] addr, input int mem_at,
                            output int lat, output logic [3:0][31:0] aseq);
        int n;
        step();
        if_request = 1'b1;
        if_addr    = addr;
        lat = 0;
        n   = 0;
        aseq = '0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (if_or_mem == 2'b01 && n < 4) begin
                aseq[n] = ram_a;
                n++;
            end
            if (if_done) break;
            if (lat == mem_at) begin
                #1;
                mem_request = 2'b01;
                mem_addr    = 32'h101;
            end
        end
        chk("fetch_done", 32'(if_done), 32'h1);
        #1 if_request = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               lat;
        logic [3:0][31:0] aseq;
        int               wr_cnt;
        int               done_seen;

        rst = 1'b0; if_request = 1'b1; if_addr = 32'h100;
        mem_request = 2'b00; mem_addr = '0; mem_data_i = '0;
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        preload(32'hFFFFFFFE, 8'h11); preload(32'hFFFFFFFF, 8'h22);
        preload(32'h0, 8'h33); preload(32'h1, 8'h44);

        // Reset with a pending fetch.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_owner", 32'(if_or_mem), 32'h0);
        chk("rst_wr", 32'(ram_wr), 32'h0);
        chk("rst_done", 32'(if_done), 32'h0);
        chk("rst_mdo", 32'(mem_data_o), 32'h0);
        step(); rst = 1'b1; if_request = 1'b0;
        step();

        // Plain fetch.
        do_fetch(32'h100, 0, lat, aseq);
        chk("fetch_lat", 32'(lat), 32'd6);
        for (int i = 0; i < 4; i++) chk("fetch_addr", aseq[i], 32'h100 + 32'(i));
        chk("fetch_inst", if_inst_o, 32'h00000513);
        @(negedge clk);
        chk("done_pulse", 32'(if_done), 32'h0);

        // Address wrap.
        do_fetch(32'hFFFFFFFE, 0, lat, aseq);
        chk("wrap_a0", aseq[0], 32'hFFFFFFFE);
        chk("wrap_a1", aseq[1], 32'hFFFFFFFF);
        chk("wrap_a2", aseq[2], 32'h00000000);
        chk("wrap_a3", aseq[3], 32'h00000001);
        chk("wrap_inst", if_inst_o, 32'h44332211);

        // Simultaneous requests in IDLE: MEM first.
        step();
        mem_request = 2'b01; mem_addr = 32'h100;
        if_request = 1'b1; if_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        chk("cont_mem_first", 32'(if_or_mem), 32'h2);
        step(); mem_request = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("cont_idle_gap", 32'(if_or_mem), 32'h0);
        chk("cont_load", 32'(mem_data_o), 32'h13);
        @(posedge clk);
        @(negedge clk);
        chk("cont_if_start", 32'(if_or_mem), 32'h1);
        for (int i = 0; i < 10 && !if_done; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("cont_done", 32'(if_done), 32'h1);
        chk("cont_inst", if_inst_o, 32'h00000513);
        #1 if_request = 1'b0;

        // MEM request during IF2 waits for the burst.
        do_fetch(32'h100, 3, lat, aseq);
        chk("late_mem_owner", 32'(if_or_mem), 32'h2);
        chk("late_mem_inst", if_inst_o, 32'h00000513);
        chk("late_mem_lat", 32'(lat), 32'd6);
        step(); mem_request = 2'b00;
        step(); step();

        // Four stores.
        step();
        mem_request = 2'b10; mem_addr = 32'h200; mem_data_i = 8'hAA;
        wr_cnt = 0;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_cnt += 32'(ram_wr);
            @(posedge clk);
            #2;
            if (i < 3) begin
                mem_addr   = 32'h201 + 32'(i);
                mem_data_i = 8'hBB + 8'(i * 17);
            end else begin
                mem_request = 2'b00;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_cnt += 32'(ram_wr);
            @(posedge clk);
        end
        chk("store_wr_cycles", 32'(wr_cnt), 32'd4);
        chk("store_ram200", 32'(prd(32'h200)), 32'hAA);
        chk("store_ram203", 32'(prd(32'h203)), 32'hDD);

        // Load them back.
        step();
        mem_request = 2'b01; mem_addr = 32'h200;
        step();
        step(); mem_addr = 32'h201;
        step(); mem_addr = 32'h202;
        @(negedge clk); chk("load_aa", 32'(mem_data_o), 32'hAA);
        step(); mem_addr = 32'h203;
        @(negedge clk); chk("load_bb", 32'(mem_data_o), 32'hBB);
        step(); mem_request = 2'b00;
        @(negedge clk); chk("load_cc", 32'(mem_data_o), 32'hCC);
        step();
        @(negedge clk); chk("load_dd", 32'(mem_data_o), 32'hDD);
        chk("load_idle", 32'(if_or_mem), 32'h0);

        // Reset in the middle of a burst.
        step();
        if_request = 1'b1; if_addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("midrst_in_if", 32'(if_or_mem), 32'h1);
        #1 rst = 1'b0; if_request = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_owner", 32'(if_or_mem), 32'h0);
        chk("midrst_done", 32'(if_done), 32'h0);
        #1 rst = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            done_seen += 32'(if_done);
        end
        chk("midrst_no_done", 32'(done_seen), 32'h0);
        do_fetch(32'h100, 0, lat, aseq);
        chk("refetch_lat", 32'(lat), 32'd6);
        chk("refetch_inst", if_inst_o, 32'h00000513);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
